// File: rtl/comb_dbus_dmem_ctrl_pkg.sv
// Shared constants for the multi-core data-memory controller.
// Default sizes, data/strobe widths, SC result codes, index-width helper.
package comb_dbus_dmem_ctrl_pkg;

  localparam int DEF_NCORES = 4;
  localparam int DEF_ADDRW  = 12;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = 4;

  localparam logic [DATA_W-1:0] SC_OK   = 32'd0;
  localparam logic [DATA_W-1:0] SC_FAIL = 32'd1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_grant_arb.sv
// Single-winner request arbiter: req_i in, one-hot gnt_o, idx_o, vld_o out.
// COMB_DBUS_RR_EN selects round-robin (adds clk_i/rst_ni); else fixed priority.
module dmem_grant_arb
  import comb_dbus_dmem_ctrl_pkg::*;
#(
  parameter int NCORES = DEF_NCORES,
  parameter int IW     = idx_w(NCORES)
) (
`ifdef COMB_DBUS_RR_EN
  input  logic              clk_i,
  input  logic              rst_ni,
`endif
  input  logic [NCORES-1:0] req_i,
  output logic [NCORES-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              vld_o
);

`ifdef COMB_DBUS_RR_EN

  logic [IW-1:0] ptr_q;

  // Search upward from the pointer, wrapping at NCORES.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      int c;
      logic [IW-1:0] ci;
      c = int'(ptr_q) + i;
      if (c >= NCORES) c = c - NCORES;
      ci = IW'(c);
      if (!vld_o && req_i[ci]) begin
        vld_o     = 1'b1;
        gnt_o[ci] = 1'b1;
        idx_o     = ci;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (vld_o) begin
      if (int'(idx_o) == NCORES - 1) ptr_q <= '0;
      else                           ptr_q <= idx_o + 1'b1;
    end
  end

`else

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      if (!vld_o && req_i[i]) begin
        vld_o    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
  end

`endif

endmodule

// File: rtl/comb_dbus_dmem_ctrl.sv
// Shared dmem controller: arbitrates per-core reads/writes (with LR/SC) onto
// one word RAM. Ports: clk_i, rst_ni (sync, active-low), packed per-core
// re/we/addr/wdata/wstrb/is_lr/is_sc in; registered rdata and comb stall out.
// Optional macro COMB_DBUS_RR_EN: round-robin grant instead of fixed priority.
module comb_dbus_dmem_ctrl
  import comb_dbus_dmem_ctrl_pkg::*;
#(
  parameter int NCORES     = DEF_NCORES,
  parameter int DMEM_ADDRW = DEF_ADDRW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NCORES-1:0]            re_packed_i,
  input  logic [NCORES-1:0]            we_packed_i,
  input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [DATA_W*NCORES-1:0]     wdata_packed_i,
  input  logic [STRB_W*NCORES-1:0]     wstrb_packed_i,
  input  logic [NCORES-1:0]            is_lr_packed_i,
  input  logic [NCORES-1:0]            is_sc_packed_i,
  output logic [DATA_W*NCORES-1:0]     rdata_packed_o,
  output logic [NCORES-1:0]            stall_packed_o
);

  localparam int IW    = idx_w(NCORES);
  localparam int DEPTH = 1 << DMEM_ADDRW;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     rdata_q [NCORES];
  logic [NCORES-1:0]     resv_valid;
  logic [DMEM_ADDRW-1:0] resv_addr [NCORES];

  logic [NCORES-1:0] req;
  logic [NCORES-1:0] gnt;
  logic [IW-1:0]     gidx;
  logic              gvld;

  // Requests are masked during reset so nothing is granted or stalled.
  assign req            = (re_packed_i | we_packed_i) & {NCORES{rst_ni}};
  assign stall_packed_o = req & ~gnt;

  dmem_grant_arb #(
    .NCORES (NCORES),
    .IW     (IW)
  ) u_arb (
`ifdef COMB_DBUS_RR_EN
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
`endif
    .req_i  (req),
    .gnt_o  (gnt),
    .idx_o  (gidx),
    .vld_o  (gvld)
  );

  logic [DMEM_ADDRW-1:0] g_addr;
  logic [DATA_W-1:0]     g_wdata;
  logic [STRB_W-1:0]     g_strb;
  logic                  g_re;
  logic                  g_we;
  logic                  g_lr;
  logic                  g_sc;

  always_comb begin
    g_addr  = addr_packed_i[DMEM_ADDRW*int'(gidx) +: DMEM_ADDRW];
    g_wdata = wdata_packed_i[DATA_W*int'(gidx) +: DATA_W];
    g_strb  = wstrb_packed_i[STRB_W*int'(gidx) +: STRB_W];
    g_re    = gvld & re_packed_i[gidx];
    g_we    = gvld & we_packed_i[gidx];
    g_lr    = is_lr_packed_i[gidx];
    g_sc    = is_sc_packed_i[gidx];
  end

  logic sc_ok;
  logic do_wr;

  assign sc_ok = resv_valid[gidx] && (resv_addr[gidx] == g_addr);
  assign do_wr = g_we && (!g_sc || sc_ok);

  // RAM contents survive reset; reset only blocks writes via req masking.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (g_strb[b]) mem[g_addr][8*b +: 8] <= g_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NCORES; k++) rdata_q[k] <= '0;
    end else if (g_re) begin
      rdata_q[gidx] <= mem[g_addr];
    end else if (g_we && g_sc) begin
      rdata_q[gidx] <= sc_ok ? SC_OK : SC_FAIL;
    end
  end

  // Any completed write kills matching reservations; wstrb is irrelevant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resv_valid <= '0;
    end else begin
      for (int j = 0; j < NCORES; j++) begin
        if (do_wr && resv_addr[j] == g_addr) resv_valid[j] <= 1'b0;
      end
      if (g_re && g_lr) begin
        resv_valid[gidx] <= 1'b1;
        resv_addr[gidx]  <= g_addr;
      end
      if (g_we && g_sc) resv_valid[gidx] <= 1'b0;
    end
  end

  always_comb begin
    rdata_packed_o = '0;
    for (int k = 0; k < NCORES; k++) begin
      rdata_packed_o[DATA_W*k +: DATA_W] = rdata_q[k];
    end
  end

endmodule

// File: tb/tb_comb_dbus_dmem_ctrl.sv
// Directed self-checking bench for comb_dbus_dmem_ctrl (4 cores, 12-bit addr).
// Covers reset, write/read, strobes, contention, LR/SC, boundaries, reset mid-stall.
module tb_comb_dbus_dmem_ctrl;

  localparam int N  = 4;
  localparam int AW = 12;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    re, we, lr, sc;
  logic [AW*N-1:0] addr;
  logic [32*N-1:0] wdata;
  logic [4*N-1:0]  wstrb;
  logic [32*N-1:0] rdata;
  logic [N-1:0]    stall;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  comb_dbus_dmem_ctrl #(
    .NCORES     (N),
    .DMEM_ADDRW (AW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .re_packed_i    (re),
    .we_packed_i    (we),
    .addr_packed_i  (addr),
    .wdata_packed_i (wdata),
    .wstrb_packed_i (wstrb),
    .is_lr_packed_i (lr),
    .is_sc_packed_i (sc),
    .rdata_packed_o (rdata),
    .stall_packed_o (stall)
  );

  task automatic idle();
    re = '0; we = '0; lr = '0; sc = '0; wstrb = '0;
  endtask

  task automatic rd(input int k, input logic [AW-1:0] a, input logic l);
    re[k] = 1'b1;
    addr[AW*k +: AW] = a;
    lr[k] = l;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a,
                    input logic [31:0] d, input logic [3:0] s,
                    input logic c);
    we[k] = 1'b1;
    addr[AW*k +: AW] = a;
    wdata[32*k +: 32] = d;
    wstrb[4*k +: 4] = s;
    sc[k] = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic solo_wr(input int k, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    idle();
    wr(k, a, d, s, 1'b0);
    tick();
    idle();
  endtask

  task automatic solo_rd(input int k, input logic [AW-1:0] a);
    idle();
    rd(k, a, 1'b0);
    tick();
    idle();
  endtask

  function automatic logic [31:0] rdq(input int k);
    return rdata[32*k +: 32];
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    n_cmp++;
    if (rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_rdata got=%h exp=0", rdata);
    end
    n_cmp++;
    if (stall !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_idle_stall got=%b exp=0000", stall);
    end
    solo_wr(2, 12'd20, 32'h12345678, 4'hF);
    rst_ni = 1'b0;
    rd(0, 12'd20, 1'b0);
    wr(2, 12'd20, 32'hBAD0BAD0, 4'hF, 1'b0);
    #1;
    n_cmp++;
    if (stall !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_req_stall got=%b exp=0000", stall);
    end
    tick();
    rst_ni = 1'b1;
    solo_rd(2, 12'd20);
    v = rdq(2);
    n_cmp++;
    if (v !== 32'h12345678) begin
      n_bad++;
      $display("FAIL reset_no_write got=%h exp=12345678", v);
    end
  endtask

  task automatic test_write_read();
    idle();
    wr(0, 12'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    #1;
    n_cmp++;
    if (stall !== 4'b0000) begin
      n_bad++;
      $display("FAIL wr_stall got=%b exp=0000", stall);
    end
    tick();
    idle();
    n_cmp++;
    if (rdq(0) !== 32'h0) begin
      n_bad++;
      $display("FAIL wr_keeps_rdata got=%h exp=0", rdq(0));
    end
    rd(0, 12'd5, 1'b0);
    #1;
    n_cmp++;
    if (stall !== 4'b0000) begin
      n_bad++;
      $display("FAIL rd_stall got=%b exp=0000", stall);
    end
    tick();
    idle();
    n_cmp++;
    if (rdq(0) !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL rd_data got=%h exp=deadbeef", rdq(0));
    end
    tick();
    n_cmp++;
    if (rdq(0) !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL rd_hold got=%h exp=deadbeef", rdq(0));
    end
  endtask

  task automatic test_strobes();
    solo_wr(0, 12'd7, 32'h11223344, 4'hF);
    solo_wr(0, 12'd7, 32'hAABBCCDD, 4'b0101);
    solo_rd(0, 12'd7);
    n_cmp++;
    if (rdq(0) !== 32'h11BB33DD) begin
      n_bad++;
      $display("FAIL strobe_merge got=%h exp=11bb33dd", rdq(0));
    end
    n_cmp++;
    if (rdq(1) !== 32'h0) begin
      n_bad++;
      $display("FAIL other_core_rdata got=%h exp=0", rdq(1));
    end
  endtask

  task automatic test_contention();
    logic [7:0] t;
    logic [3:0] e;
    for (int i = 0; i < N; i++)
      solo_wr(0, 12'(100 + i), 32'hC0DE0000 + i, 4'hF);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    idle();
    for (int k = 0; k < N; k++) rd(k, 12'(100 + k), 1'b0);
    for (int i = 0; i < N; i++) begin
      #1;
      t = 8'hF << (i + 1);
      e = t[3:0];
      n_cmp++;
      if (stall !== e) begin
        n_bad++;
        $display("FAIL contend_stall_%0d got=%b exp=%b", i, stall, e);
      end
      tick();
      n_cmp++;
      if (rdq(i) !== 32'hC0DE0000 + i) begin
        n_bad++;
        $display("FAIL contend_rdata_%0d got=%h exp=%h",
                 i, rdq(i), 32'hC0DE0000 + i);
      end
      re[i] = 1'b0;
    end
    tick();
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (rdq(k) !== 32'hC0DE0000 + k) begin
        n_bad++;
        $display("FAIL contend_stable_%0d got=%h exp=%h",
                 k, rdq(k), 32'hC0DE0000 + k);
      end
    end
  endtask

  task automatic test_lrsc_success();
    solo_wr(0, 12'd9, 32'h77, 4'hF);
    idle();
    rd(1, 12'd9, 1'b1);
    tick();
    idle();
    n_cmp++;
    if (rdq(1) !== 32'h77) begin
      n_bad++;
      $display("FAIL lr_data got=%h exp=77", rdq(1));
    end
    wr(1, 12'd9, 32'h1, 4'hF, 1'b1);
    tick();
    idle();
    n_cmp++;
    if (rdq(1) !== 32'h0) begin
      n_bad++;
      $display("FAIL sc_ok_code got=%h exp=0", rdq(1));
    end
    solo_rd(0, 12'd9);
    n_cmp++;
    if (rdq(0) !== 32'h1) begin
      n_bad++;
      $display("FAIL sc_ok_mem got=%h exp=1", rdq(0));
    end
  endtask

  task automatic test_lrsc_fail();
    solo_wr(3, 12'd9, 32'h99, 4'hF);
    idle();
    rd(0, 12'd9, 1'b1);
    tick();
    idle();
    n_cmp++;
    if (rdq(0) !== 32'h99) begin
      n_bad++;
      $display("FAIL lr2_data got=%h exp=99", rdq(0));
    end
    solo_wr(2, 12'd9, 32'h5, 4'hF);
    wr(0, 12'd9, 32'h7, 4'hF, 1'b1);
    tick();
    idle();
    n_cmp++;
    if (rdq(0) !== 32'h1) begin
      n_bad++;
      $display("FAIL sc_fail_code got=%h exp=1", rdq(0));
    end
    solo_rd(1, 12'd9);
    n_cmp++;
    if (rdq(1) !== 32'h5) begin
      n_bad++;
      $display("FAIL sc_fail_mem got=%h exp=5", rdq(1));
    end
    solo_rd(0, 12'd9);
    wr(0, 12'd9, 32'h7, 4'hF, 1'b1);
    tick();
    idle();
    n_cmp++;
    if (rdq(0) !== 32'h1) begin
      n_bad++;
      $display("FAIL sc_resv_cleared got=%h exp=1", rdq(0));
    end
  endtask

  task automatic test_boundary();
    solo_wr(1, 12'd0, 32'h00000A0A, 4'hF);
    solo_wr(3, 12'd4095, 32'hFEEDF00D, 4'hF);
    solo_rd(3, 12'd4095);
    n_cmp++;
    if (rdq(3) !== 32'hFEEDF00D) begin
      n_bad++;
      $display("FAIL top_addr got=%h exp=feedf00d", rdq(3));
    end
    solo_rd(1, 12'd0);
    n_cmp++;
    if (rdq(1) !== 32'h00000A0A) begin
      n_bad++;
      $display("FAIL addr0_no_wrap got=%h exp=00000a0a", rdq(1));
    end
    solo_wr(0, 12'd30, 32'h30303030, 4'hF);
    idle();
    rd(3, 12'd30, 1'b1);
    tick();
    idle();
    solo_wr(1, 12'd30, 32'hFFFFFFFF, 4'h0);
    solo_rd(0, 12'd30);
    n_cmp++;
    if (rdq(0) !== 32'h30303030) begin
      n_bad++;
      $display("FAIL zero_strb_data got=%h exp=30303030", rdq(0));
    end
    wr(3, 12'd30, 32'h1234, 4'hF, 1'b1);
    tick();
    idle();
    n_cmp++;
    if (rdq(3) !== 32'h1) begin
      n_bad++;
      $display("FAIL zero_strb_kill got=%h exp=1", rdq(3));
    end
    solo_rd(0, 12'd30);
    n_cmp++;
    if (rdq(0) !== 32'h30303030) begin
      n_bad++;
      $display("FAIL sc_fail_nowrite got=%h exp=30303030", rdq(0));
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [3:0] e;
`ifdef COMB_DBUS_RR_EN
    e = 4'b0001;
`else
    e = 4'b0010;
`endif
    solo_wr(2, 12'd50, 32'h50505050, 4'hF);
    solo_wr(1, 12'd41, 32'h41414141, 4'hF);
    idle();
    rd(0, 12'd50, 1'b1);
    tick();
    idle();
    rd(0, 12'd40, 1'b0);
    wr(1, 12'd41, 32'hBADBAD00, 4'hF, 1'b0);
    #1;
    n_cmp++;
    if (stall !== e) begin
      n_bad++;
      $display("FAIL midstall_pre got=%b exp=%b", stall, e);
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 4'b0000) begin
      n_bad++;
      $display("FAIL midstall_rst_stall got=%b exp=0000", stall);
    end
    tick();
    n_cmp++;
    if (rdata !== '0) begin
      n_bad++;
      $display("FAIL midstall_rdata got=%h exp=0", rdata);
    end
    rst_ni = 1'b1;
    solo_rd(2, 12'd41);
    n_cmp++;
    if (rdq(2) !== 32'h41414141) begin
      n_bad++;
      $display("FAIL midstall_no_write got=%h exp=41414141", rdq(2));
    end
    wr(0, 12'd50, 32'h55, 4'hF, 1'b1);
    tick();
    idle();
    n_cmp++;
    if (rdq(0) !== 32'h1) begin
      n_bad++;
      $display("FAIL midstall_resv_clr got=%h exp=1", rdq(0));
    end
    solo_rd(2, 12'd50);
    n_cmp++;
    if (rdq(2) !== 32'h50505050) begin
      n_bad++;
      $display("FAIL midstall_sc_nowrite got=%h exp=50505050", rdq(2));
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    addr   = '0;
    wdata  = '0;
    idle();
    tick();
    tick();
    rst_ni = 1'b1;
    test_reset();
    test_write_read();
    test_strobes();
    test_contention();
    test_lrsc_success();
    test_lrsc_fail();
    test_boundary();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
